// File: rtl/req_ack_responder_if.sv
// Handshake bundle between an initiator and the req/ack responder.
// The master side drives requests and interrupts; the slave side answers.
interface req_ack_responder_if #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic             req;
    logic [TAG_W-1:0] req_tag;
    logic             interrupt;
    logic             ack;
    logic [TAG_W-1:0] ack_tag;
    logic             busy;
    logic [CNT_W-1:0] ack_cnt;
    logic [CNT_W-1:0] abort_cnt;

    modport master (
        output req, req_tag, interrupt,
        input  ack, ack_tag, busy, ack_cnt, abort_cnt
    );

    modport slave (
        input  req, req_tag, interrupt,
        output ack, ack_tag, busy, ack_cnt, abort_cnt
    );
endinterface

// File: rtl/req_ack_responder.sv
// Responder end of the req/ack protocol: every request is acknowledged LATENCY
// ticks later with its tag; an interrupt drops everything still in flight.
module req_ack_responder #(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    req_ack_responder_if.slave bus
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("req_ack_responder: LATENCY must be >= 1");
    end

    // The last pipeline stage is the output register; its entry is being
    // delivered this tick and is never counted as dropped by an interrupt.
    localparam logic [LATENCY-1:0] OUT_BIT = LATENCY'(1) << (LATENCY - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic [LATENCY-1:0]            vld_q, vld_d;
    logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]              ack_cnt_q, ack_cnt_d;
    logic [CNT_W-1:0]              abort_cnt_q, abort_cnt_d;
    logic                          dropped;

    // Invalid stages carry a zero tag so ack_tag reads 0 whenever ack is low.
    always_comb begin
        vld_d = '0;
        tag_d = '0;
        if (!bus.interrupt) begin
            vld_d[0] = bus.req;
            tag_d[0] = bus.req ? bus.req_tag : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    assign dropped = bus.interrupt && (bus.req || (|(vld_q & ~OUT_BIT)));

    always_comb begin
        ack_cnt_d   = ack_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (vld_q[LATENCY-1] && (ack_cnt_q != CNT_MAX)) begin
            ack_cnt_d = ack_cnt_q + 1'b1;
        end
        if (dropped && (abort_cnt_q != CNT_MAX)) begin
            abort_cnt_d = abort_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples
    // the pre-edge value of its neighbour; the tag pipeline is reset too, since
    // it is only LATENCY entries and must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            tag_q       <= '0;
            ack_cnt_q   <= '0;
            abort_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            ack_cnt_q   <= ack_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign bus.ack       = vld_q[LATENCY-1];
    assign bus.ack_tag   = tag_q[LATENCY-1];
    assign bus.busy      = |vld_q;
    assign bus.ack_cnt   = ack_cnt_q;
    assign bus.abort_cnt = abort_cnt_q;

endmodule

// File: doc/req_ack_responder.md
Name: req_ack_responder

Overview:
- Responder end of the single-bit req/ack protocol with interrupt abort.
- Every request sampled on `clk` is acknowledged exactly LATENCY ticks later, carrying the request's tag.
- An interrupt discards every outstanding obligation, matching the accept_on semantics used by the initiator-side checkers.
- Sits beside initiator blocks in the verification top; with LATENCY=1 its output satisfies req |=> ack.

Parameters:
- LATENCY, 1, ticks from req sample to ack sample; must be >=1, else elaboration error.
- TAG_W, 4, width of request/ack tag.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request strobe, one request per tick where high.
- req_tag  in  TAG_W  tag accompanying req.
- interrupt  in  1  abort; discards all outstanding requests.
- ack  out  1  acknowledge, registered.
- ack_tag  out  TAG_W  tag of the acknowledged request, registered.
- busy  out  1  high while any request is outstanding and not yet acked.
- ack_cnt  out  CNT_W  number of ack ticks delivered, saturating.
- abort_cnt  out  CNT_W  number of abort events that dropped at least one request, saturating.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert usage):
  - ack=0, ack_tag=0, busy=0, ack_cnt=0, abort_cnt=0.
  - All pipeline valid bits and tags cleared.
  - Reset mid-operation drops every outstanding request with no ack and no abort_cnt increment.
- Structure: shift pipeline of LATENCY entries (valid, tag). The last entry is the ack/ack_tag output register.
- Latency:
  - req=1 sampled at tick k with interrupt=0: ack=1 and ack_tag=req_tag are sampled at tick k+LATENCY.
  - For LATENCY=1 the output register loads at tick k.
- Back-to-back: req high on N consecutive ticks yields ack high on N consecutive ticks, tags in order. There is no backpressure and no capacity limit.
- ack_tag when ack=0: holds 0.
- Interrupt (interrupt=1 sampled at tick k):
  - All in-flight entries are cleared, including the output register.
  - A req sampled at the same tick k is also discarded.
  - ack is sampled 0 at tick k+1.
  - An ack already sampled high at tick k counts as delivered.
  - abort_cnt increments by 1 at tick k if at least one entry was dropped (incoming req or any valid entry other than the one being delivered at k). Otherwise it is unchanged.
  - A req sampled at tick k+1 with interrupt=0 is accepted normally.
- busy: combinational OR of all pipeline valid bits, including the output register.
- ack_cnt: increments at every tick where ack is sampled 1. Saturates at 2^CNT_W-1. No wrap.
- abort_cnt: saturates at 2^CNT_W-1. No wrap.
- X on req/interrupt while rst_n=0: ignored.

Test Plan:
- LATENCY=1, TAG_W=4, req=1 with tag 0x5 at tick 3 only -> ack=1 and ack_tag=0x5 at tick 4 only; busy=1 between ticks 3 and 4; ack_cnt=1.
- LATENCY=3, req high ticks 10–13 with tags 1,2,3,4 -> ack high ticks 13–16 with tags 1,2,3,4; ack_cnt=4; busy low after tick 16.
- LATENCY=3, req at tick 5 (tag 7), interrupt at tick 6 -> no ack ticks 6–9; abort_cnt=1; busy low after tick 6.
- LATENCY=1:
  - req and interrupt both high at tick 8 -> ack=0 at tick 9, abort_cnt=1.
  - req alone at tick 9 -> ack=1 at tick 10.
- LATENCY=2, req at ticks 2 and 3, rst_n pulsed low between ticks 3 and 4 -> ack never asserted; all outputs 0 immediately on rst_n fall; abort_cnt=0.
- CNT_W=2, LATENCY=1, req high 6 consecutive ticks -> ack_cnt counts 1,2,3,3,3,3 (saturates at 3).
